otter_dcache: RTL and testbench
===============================

Name: otter_dcache

Overview:
- Direct-mapped, read-allocate, write-through, no-write-allocate data cache.
- Sits between the OTTER pipeline memory stage and the byte-addressable dual-port memory.
- Consumes the memory's four-word line read (one-cycle latency) to fill lines, and forwards every store to memory.
- Performs load size/sign slicing for hits; addresses >= 32'h11000000 bypass as uncached IO.

Parameters:
- LINES, 16, number of cache lines (power of 2); INDEX_W = log2(LINES).
- IO_BASE, 32'h11000000, first uncached address.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- CPU_ADDR  in  32  byte address of load/store
- CPU_RD  in  1  load request
- CPU_WR  in  1  store request
- CPU_SIZE  in  2  0=byte, 1=half, 2=word
- CPU_SIGN  in  1  1=unsigned load (lbu/lhu)
- CPU_WDATA  in  32  store data, right-aligned
- CPU_FLUSH  in  1  one-cycle pulse: invalidate all lines
- CPU_RDATA  out  32  load result, valid the cycle after the accepted request
- CPU_STALL  out  1  request not accepted; CPU holds all inputs stable
- CPU_ERR  out  1  misaligned access (half at offset 3, word at offset != 0)
- MEM_ADDR2  out  32  memory data-port address
- MEM_READ2  out  1  memory read strobe
- MEM_WRITE2  out  1  memory write strobe
- MEM_SIZE  out  2  store size to memory
- MEM_SIGN  out  1  pass-through of CPU_SIGN
- MEM_DIN2  out  32  store data to memory
- MEM_R0..MEM_R3  in  32 each  line words 0..3, valid the cycle after MEM_READ2
- MEM_DOUT2  in  32  sliced memory/IO read data, valid the cycle after MEM_READ2
- HIT_CNT, MISS_CNT  out  32 each  performance counters, wrap at 2^32

Behaviour:
- Address split: offset = addr[3:0] (word = [3:2], byte = [1:0]), index = addr[4 +: INDEX_W], tag = addr[31:4+INDEX_W].
- Storage: valid bit, tag and 4x32 data per line. Tag/valid are read combinationally.
- Reset: all valid bits = 0, state = IDLE. CPU_RDATA, counters, io_pending, MEM_READ2 and MEM_WRITE2 all = 0. Data array is not reset.
- FSM states: IDLE, FILL.
- IDLE, cacheable load, hit:
  - CPU_STALL = 0; HIT_CNT += 1.
  - Sliced data is registered into CPU_RDATA at the next edge.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- IDLE, cacheable load, miss:
  - CPU_STALL = 1; MEM_READ2 = 1; MEM_ADDR2 = {addr[31:4], 4'b0}; MISS_CNT += 1; next state FILL.
- FILL:
  - CPU_STALL = 1; write MEM_R0..R3 into the data words; set tag; valid = 1; next state IDLE.
  - The held request then hits: miss penalty is exactly 2 stall cycles.
- Store (IDLE, any address):
  - No stall. MEM_WRITE2 = 1 in the same cycle; MEM_ADDR2, MEM_SIZE and MEM_DIN2 are taken from the CPU.
  - Cacheable hit: byte lanes are merged into the line at the same edge (sb lane = addr[1:0]; sh lanes addr[1:0] and +1; sw all lanes).
  - Miss: line unchanged. Counters unchanged.
- IO load (addr >= IO_BASE):
  - No stall; MEM_READ2 = 1 with the raw address; io_pending is set.
  - Next cycle CPU_RDATA = MEM_DOUT2 (combinational mux on io_pending). Never allocates.
- CPU_RD and CPU_WR together: store has priority; the load is ignored.
- CPU_ERR:
  - Combinational.
  - A misaligned load or store raises it, issues no memory strobe, does not modify the cache, and leaves CPU_RDATA unchanged.
- CPU_FLUSH:
  - Clears all valid bits at the next edge.
  - If asserted in FILL, the fill still writes data but valid stays 0. Flush wins, so the held request misses again.
- CPU_RDATA holds its value when no load is accepted.
- RST_N low mid-FILL: immediate return to IDLE, all lines invalid, strobes deasserted.

Decomposition:
- Package otter_dcache_pkg holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - state enum (IDLE, FILL)
  - IO_BASE
  - address-field width functions
- One natural sub-module: otter_load_slicer (combinational size/sign/offset extraction from a 32-bit word), reused on the hit path.

Test Plan:
- Cold lw 0x100, memory words 0x100..0x10C = A,B,C,D -> STALL high 2 cycles, MEM_READ2 pulse with address 0x100, then CPU_RDATA = A; MISS_CNT = 1.
- After that fill, lw 0x108 -> no stall, CPU_RDATA = C next cycle; HIT_CNT = 1.
- Cached word 0x80FF7F01 at 0x100: lb 0x103 -> 0xFFFFFF80; lbu 0x103 -> 0x00000080; lh 0x102 -> 0xFFFF80FF; lhu 0x100 -> 0x00007F01.
- sb 0xAA at 0x101 on a hit line -> MEM_WRITE2 = 1 with SIZE = 0; a following lw 0x100 hits and returns 0x80FFAA01. Store to an uncached line -> line stays invalid.
- lw 0x11000000 with MEM_DOUT2 = 0x5 -> no stall, CPU_RDATA = 0x5 next cycle, counters unchanged; lw 0x102 -> CPU_ERR = 1, no strobe.
- Miss to 0x200, CPU_FLUSH asserted during FILL -> the request re-misses (MISS_CNT += 2); RST_N low mid-FILL -> STALL = 0, state IDLE, all misses thereafter.

Source files
------------

// File: rtl/otter_dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otter_dcache_pkg
// Description : Shared encodings, FSM state type, IO base address and
//               address-field width helpers for the OTTER data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package otter_dcache_pkg;

    // Access size encodings shared by CPU and memory ports
    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    // First address that bypasses the cache
    localparam logic [31:0] c_IO_BASE = 32'h1100_0000;

    // Cache controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Index field width for a given line count (lines are 16 bytes)
    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag field width: whatever is left above index and 4-bit offset
    function automatic int tag_width(input int lines);
        return 32 - 4 - $clog2(lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_dcache_if.sv
`default_nettype none
// ============================================================================
// Module      : otter_cpu_if / otter_mem_if
// Description : CPU-side request bus and memory-side data-port bus of the
//               OTTER data cache. On the CPU bus the pipeline is master; on
//               the memory bus the cache is master.
// Revision    : 1.0 - initial release
// ============================================================================
interface otter_cpu_if;
    logic [31:0] CPU_ADDR;
    logic        CPU_RD;
    logic        CPU_WR;
    logic [1:0]  CPU_SIZE;
    logic        CPU_SIGN;
    logic [31:0] CPU_WDATA;
    logic        CPU_FLUSH;
    logic [31:0] CPU_RDATA;
    logic        CPU_STALL;
    logic        CPU_ERR;

    modport master (
        output CPU_ADDR, CPU_RD, CPU_WR, CPU_SIZE, CPU_SIGN, CPU_WDATA, CPU_FLUSH,
        input  CPU_RDATA, CPU_STALL, CPU_ERR
    );

    modport slave (
        input  CPU_ADDR, CPU_RD, CPU_WR, CPU_SIZE, CPU_SIGN, CPU_WDATA, CPU_FLUSH,
        output CPU_RDATA, CPU_STALL, CPU_ERR
    );
endinterface

interface otter_mem_if;
    logic [31:0] MEM_ADDR2;
    logic        MEM_READ2;
    logic        MEM_WRITE2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DIN2;
    logic [31:0] MEM_R0;
    logic [31:0] MEM_R1;
    logic [31:0] MEM_R2;
    logic [31:0] MEM_R3;
    logic [31:0] MEM_DOUT2;

    modport master (
        output MEM_ADDR2, MEM_READ2, MEM_WRITE2, MEM_SIZE, MEM_SIGN, MEM_DIN2,
        input  MEM_R0, MEM_R1, MEM_R2, MEM_R3, MEM_DOUT2
    );

    modport slave (
        input  MEM_ADDR2, MEM_READ2, MEM_WRITE2, MEM_SIZE, MEM_SIGN, MEM_DIN2,
        output MEM_R0, MEM_R1, MEM_R2, MEM_R3, MEM_DOUT2
    );
endinterface
`default_nettype wire

// File: rtl/otter_dcache_load_slicer.sv
`default_nettype none
// ============================================================================
// Module      : otter_load_slicer
// Description : Extracts a byte, half or word from a 32-bit word at the given
//               byte offset, sign- or zero-extending to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_load_slicer
    import otter_dcache_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_offset,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    output logic [31:0]      o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];

    // Half-word select; offset 3 is misaligned upstream so it shares the top half
    always_comb begin
        w_half = i_word[15:0];
        case (i_offset)
            2'd0:    w_half = i_word[15:0];
            2'd1:    w_half = i_word[23:8];
            default: w_half = i_word[31:16];
        endcase
    end

    // Size/sign extension of the selected field
    always_comb begin
        o_data = i_word;
        case (i_size)
            c_SZ_BYTE: o_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            c_SZ_HALF: o_data = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default:   o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/otter_dcache.sv
`default_nettype none
// ============================================================================
// Module      : otter_dcache
// Description : Direct-mapped, read-allocate, write-through, no-write-allocate
//               data cache between the OTTER memory stage and the dual-port
//               memory. Addresses at or above IO_BASE bypass as uncached IO.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_dcache
    import otter_dcache_pkg::*;
#(
    parameter int          LINES   = 16,
    parameter logic [31:0] IO_BASE = c_IO_BASE
) (
    input  wire logic   CLK,
    input  wire logic   RST_N,
    otter_cpu_if.slave  cpu,
    otter_mem_if.master mem,
    output logic [31:0] HIT_CNT,
    output logic [31:0] MISS_CNT
);

    localparam int c_INDEX_W = index_width(LINES);
    localparam int c_TAG_W   = tag_width(LINES);

    state_t               r_state;
    logic [LINES-1:0]     r_valid;
    logic [c_TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]          r_data [LINES][4];
    logic [31:0]          r_rdata;
    logic                 r_io_pending;
    logic                 r_replay;
    logic [31:0]          r_hit_cnt;
    logic [31:0]          r_miss_cnt;

    logic [c_INDEX_W-1:0] w_index;
    logic [c_TAG_W-1:0]   w_tag;
    logic [1:0]           w_word;
    logic [1:0]           w_byte;
    logic                 w_misaligned;
    logic                 w_io;
    logic                 w_hit;
    logic                 w_idle;
    logic                 w_store;
    logic                 w_load;
    logic                 w_ld_hit;
    logic                 w_ld_miss;
    logic                 w_ld_io;
    logic [31:0]          w_cur_word;
    logic [31:0]          w_hit_data;
    logic [31:0]          w_wdata_sh;
    logic [3:0]           w_lane_we;
    logic [31:0]          w_merged;

    assign w_index      = cpu.CPU_ADDR[4 +: c_INDEX_W];
    assign w_tag        = cpu.CPU_ADDR[31 -: c_TAG_W];
    assign w_word       = cpu.CPU_ADDR[3:2];
    assign w_byte       = cpu.CPU_ADDR[1:0];
    assign w_misaligned = ((cpu.CPU_SIZE == c_SZ_HALF) && (w_byte == 2'd3)) ||
                          (cpu.CPU_SIZE[1] && (w_byte != 2'd0));
    assign w_io         = (cpu.CPU_ADDR >= IO_BASE);
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_idle       = (r_state == IDLE);

    // Store has priority over a simultaneous load; misaligned requests do nothing
    assign w_store   = w_idle && cpu.CPU_WR && !w_misaligned;
    assign w_load    = w_idle && cpu.CPU_RD && !cpu.CPU_WR && !w_misaligned;
    assign w_ld_hit  = w_load && !w_io && w_hit;
    assign w_ld_miss = w_load && !w_io && !w_hit;
    assign w_ld_io   = w_load && w_io;

    assign w_cur_word = r_data[w_index][w_word];

    otter_load_slicer u_slicer (
        .i_word     (w_cur_word),
        .i_offset   (w_byte),
        .i_size     (cpu.CPU_SIZE),
        .i_unsigned (cpu.CPU_SIGN),
        .o_data     (w_hit_data)
    );

    // Byte-lane enables for merging a store into a resident line
    always_comb begin
        w_lane_we = 4'b0000;
        case (cpu.CPU_SIZE)
            c_SZ_BYTE: w_lane_we[w_byte] = 1'b1;
            c_SZ_HALF: begin
                w_lane_we[w_byte]         = 1'b1;
                w_lane_we[w_byte + 2'd1]  = 1'b1;
            end
            default:   w_lane_we = 4'b1111;
        endcase
    end

    assign w_wdata_sh = cpu.CPU_WDATA << {w_byte, 3'b000};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_merged[8*k +: 8] = w_lane_we[k] ? w_wdata_sh[8*k +: 8] : w_cur_word[8*k +: 8];
    end

    // Data and tag arrays: line fill in FILL, write-through merge on a store hit.
    // The CPU holds its request through FILL, so the live index/tag name the line.
    always_ff @(posedge CLK) begin
        if (r_state == FILL) begin
            r_data[w_index][0] <= mem.MEM_R0;
            r_data[w_index][1] <= mem.MEM_R1;
            r_data[w_index][2] <= mem.MEM_R2;
            r_data[w_index][3] <= mem.MEM_R3;
            r_tag[w_index]     <= w_tag;
        end else if (w_store && !w_io && w_hit) begin
            r_data[w_index][w_word] <= w_merged;
        end
    end

    // Controller FSM, valid bits, load result register and performance counters.
    // The hit that replays a just-filled request is not counted again.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_rdata      <= 32'd0;
            r_io_pending <= 1'b0;
            r_replay     <= 1'b0;
            r_hit_cnt    <= 32'd0;
            r_miss_cnt   <= 32'd0;
        end else begin
            r_io_pending <= w_ld_io;
            r_replay     <= 1'b0;
            if (r_io_pending) begin
                r_rdata <= mem.MEM_DOUT2;
            end
            case (r_state)
                IDLE: begin
                    if (w_ld_hit) begin
                        r_rdata <= w_hit_data;
                        if (!r_replay) begin
                            r_hit_cnt <= r_hit_cnt + 32'd1;
                        end
                    end
                    if (w_ld_miss) begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    r_valid[w_index] <= 1'b1;
                    r_replay         <= 1'b1;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // A flush overrides the valid bit a concurrent fill would set
            if (cpu.CPU_FLUSH) begin
                r_valid <= '0;
            end
        end
    end

    assign cpu.CPU_RDATA = r_io_pending ? mem.MEM_DOUT2 : r_rdata;
    assign cpu.CPU_STALL = RST_N && (w_ld_miss || (r_state == FILL));
    assign cpu.CPU_ERR   = (cpu.CPU_RD || cpu.CPU_WR) && w_misaligned;

    assign mem.MEM_READ2  = RST_N && (w_ld_miss || w_ld_io);
    assign mem.MEM_WRITE2 = RST_N && w_store;
    assign mem.MEM_ADDR2  = (w_ld_miss || (r_state == FILL)) ? {cpu.CPU_ADDR[31:4], 4'b0000}
                                                             : cpu.CPU_ADDR;
    assign mem.MEM_SIZE   = cpu.CPU_SIZE;
    assign mem.MEM_SIGN   = cpu.CPU_SIGN;
    assign mem.MEM_DIN2   = cpu.CPU_WDATA;

    assign HIT_CNT  = r_hit_cnt;
    assign MISS_CNT = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_otter_dcache.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_dcache
// Description : Self-checking bench for otter_dcache. A byte-array memory
//               answers the cache's data port; a separate reference memory and
//               a line-presence table predict every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_dcache;

    localparam logic [31:0] IOB = 32'h1100_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    otter_cpu_if cpu_bus ();
    otter_mem_if mem_bus ();

    otter_dcache #(.LINES(16), .IO_BASE(IOB)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .cpu      (cpu_bus),
        .mem      (mem_bus),
        .HIT_CNT  (hit_cnt),
        .MISS_CNT (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory (written only through the DUT's strobes)
    logic [7:0]  mem_arr [2048];
    logic [10:0] wa;
    logic [10:0] la;
    assign wa = mem_bus.MEM_ADDR2[10:0];
    assign la = {mem_bus.MEM_ADDR2[10:4], 4'h0};

    function automatic logic [31:0] io_val(input logic [31:0] a);
        return a - IOB + 32'd5;
    endfunction

    function automatic logic [31:0] env_word(input logic [10:0] a);
        return {mem_arr[a + 11'd3], mem_arr[a + 11'd2], mem_arr[a + 11'd1], mem_arr[a]};
    endfunction

    always @(posedge clk) begin
        if (mem_bus.MEM_WRITE2 && mem_bus.MEM_ADDR2 < 32'd2048) begin
            case (mem_bus.MEM_SIZE)
                2'd0: mem_arr[wa] <= mem_bus.MEM_DIN2[7:0];
                2'd1: begin
                    mem_arr[wa]         <= mem_bus.MEM_DIN2[7:0];
                    mem_arr[wa + 11'd1] <= mem_bus.MEM_DIN2[15:8];
                end
                default: begin
                    mem_arr[wa]         <= mem_bus.MEM_DIN2[7:0];
                    mem_arr[wa + 11'd1] <= mem_bus.MEM_DIN2[15:8];
                    mem_arr[wa + 11'd2] <= mem_bus.MEM_DIN2[23:16];
                    mem_arr[wa + 11'd3] <= mem_bus.MEM_DIN2[31:24];
                end
            endcase
        end
        if (mem_bus.MEM_READ2) begin
            mem_bus.MEM_R0    <= env_word(la);
            mem_bus.MEM_R1    <= env_word(la + 11'd4);
            mem_bus.MEM_R2    <= env_word(la + 11'd8);
            mem_bus.MEM_R3    <= env_word(la + 11'd12);
            mem_bus.MEM_DOUT2 <= io_val(mem_bus.MEM_ADDR2);
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [2048];
    logic        m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
    logic [31:0] exp_rdata;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] size,
                                              input logic uns);
        logic [10:0] a;
        logic [7:0]  b;
        logic [15:0] h;
        a = addr[10:0];
        b = ref_mem[a];
        h = {ref_mem[a + 11'd1], ref_mem[a]};
        case (size)
            2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return {ref_mem[a + 11'd3], ref_mem[a + 11'd2], h};
        endcase
    endfunction

    task automatic idle_inputs();
        cpu_bus.CPU_RD    = 1'b0;
        cpu_bus.CPU_WR    = 1'b0;
        cpu_bus.CPU_FLUSH = 1'b0;
    endtask

    task automatic clear_model_valid();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One CPU request: checks every cycle until acceptance, then the result cycle
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic flush_mid,
                          output int stalls, output logic [31:0] rdata_seen, output logic err_seen);
        logic        err, io, present, ld, fm, exp_rd, exp_wr;
        logic [3:0]  idx;
        logic [23:0] tg;
        int          exp_stall;
        idx = addr[7:4];
        tg  = addr[31:8];
        err = (rd || wr) && (((size == 2'd1) && (addr[1:0] == 2'd3)) ||
                             ((size == 2'd2) && (addr[1:0] != 2'd0)));
        io  = (addr >= IOB);
        ld  = rd && !wr && !err;
        present   = !io && m_valid[idx] && (m_tag[idx] == tg);
        exp_stall = (ld && !io && !present) ? 2 : 0;
        fm        = flush_mid && (exp_stall != 0);
        if (fm) exp_stall = 4;

        cpu_bus.CPU_ADDR  = addr;
        cpu_bus.CPU_RD    = rd;
        cpu_bus.CPU_WR    = wr;
        cpu_bus.CPU_SIZE  = size;
        cpu_bus.CPU_SIGN  = uns;
        cpu_bus.CPU_WDATA = wdata;
        stalls   = 0;
        err_seen = 1'b0;
        for (int c = 0; c <= exp_stall; c++) begin
            @(negedge clk);
            if (cpu_bus.CPU_STALL) stalls++;
            if (c == 0) err_seen = cpu_bus.CPU_ERR;
            chk("stall", {31'd0, cpu_bus.CPU_STALL}, {31'd0, (c < exp_stall)});
            chk("err", {31'd0, cpu_bus.CPU_ERR}, {31'd0, err});
            exp_wr = (c == 0) && wr && !err;
            exp_rd = (c == 0) ? (ld && (io || !present)) : ((c < exp_stall) && (c % 2 == 0));
            chk("mem_write", {31'd0, mem_bus.MEM_WRITE2}, {31'd0, exp_wr});
            chk("mem_read", {31'd0, mem_bus.MEM_READ2}, {31'd0, exp_rd});
            if (exp_wr) begin
                chk("wr_addr", mem_bus.MEM_ADDR2, addr);
                chk("wr_size", {30'd0, mem_bus.MEM_SIZE}, {30'd0, size});
                chk("wr_din", mem_bus.MEM_DIN2, wdata);
            end
            if (exp_rd) chk("rd_addr", mem_bus.MEM_ADDR2, io ? addr : {addr[31:4], 4'h0});
            if (fm && c == 1) cpu_bus.CPU_FLUSH = 1'b1;
            if (fm && c == 2) cpu_bus.CPU_FLUSH = 1'b0;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        if (fm) clear_model_valid();
        if (wr && !err && !io) begin
            ref_mem[addr[10:0]] = wdata[7:0];
            if (size != 2'd0) ref_mem[addr[10:0] + 11'd1] = wdata[15:8];
            if (size == 2'd2) begin
                ref_mem[addr[10:0] + 11'd2] = wdata[23:16];
                ref_mem[addr[10:0] + 11'd3] = wdata[31:24];
            end
        end
        if (ld) begin
            if (io) begin
                exp_rdata = io_val(addr);
            end else begin
                if (present) exp_hit = exp_hit + 32'd1;
                else begin
                    exp_miss     = exp_miss + (fm ? 32'd2 : 32'd1);
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                end
                exp_rdata = exp_load(addr, size, uns);
            end
        end
        @(negedge clk);
        rdata_seen = cpu_bus.CPU_RDATA;
        chk("rdata", cpu_bus.CPU_RDATA, exp_rdata);
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("miss_cnt", miss_cnt, exp_miss);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        cpu_bus.CPU_FLUSH = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, cpu_bus.CPU_STALL}, 32'd0);
        chk("flush_rd", {31'd0, mem_bus.MEM_READ2}, 32'd0);
        @(posedge clk);
        #1;
        cpu_bus.CPU_FLUSH = 1'b0;
        clear_model_valid();
    endtask

    initial begin
        int          st;
        logic [31:0] rv;
        logic        ev;
        logic [7:0]  bv;
        total = 0;
        bad   = 0;
        exp_hit = 0; exp_miss = 0; exp_rdata = 0;
        clear_model_valid();
        for (int i = 0; i < 16; i++) m_tag[i] = '0;
        for (int i = 0; i < 2048; i++) begin
            bv = 8'($urandom);
            mem_arr[i] = bv;
            ref_mem[i] = bv;
        end
        for (int w = 0; w < 4; w++) begin
            rv = (w == 0) ? 32'h80FF7F01 : (w == 1) ? 32'h22222222 :
                 (w == 2) ? 32'h33333333 : 32'h44444444;
            for (int b = 0; b < 4; b++) begin
                mem_arr[256 + 4*w + b] = rv[8*b +: 8];
                ref_mem[256 + 4*w + b] = rv[8*b +: 8];
            end
        end
        cpu_bus.CPU_ADDR = 0; cpu_bus.CPU_SIZE = 0; cpu_bus.CPU_SIGN = 0; cpu_bus.CPU_WDATA = 0;
        idle_inputs();
        mem_bus.MEM_R0 = 0; mem_bus.MEM_R1 = 0; mem_bus.MEM_R2 = 0; mem_bus.MEM_R3 = 0;
        mem_bus.MEM_DOUT2 = 0;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_rdata", cpu_bus.CPU_RDATA, 32'd0);
        chk("rst_hit", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        chk("rst_stall", {31'd0, cpu_bus.CPU_STALL}, 32'd0);
        chk("rst_write", {31'd0, mem_bus.MEM_WRITE2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios with hand-computed values
        do_req(1, 0, 32'h100, 2, 0, 0, 0, st, rv, ev);
        chk("cold_stalls", st, 2);
        chk("cold_rdata", rv, 32'h80FF7F01);
        chk("cold_miss", miss_cnt, 32'd1);
        do_req(1, 0, 32'h108, 2, 0, 0, 0, st, rv, ev);
        chk("hit_stalls", st, 0);
        chk("hit_rdata", rv, 32'h33333333);
        chk("hit_cnt1", hit_cnt, 32'd1);
        do_req(1, 0, 32'h103, 0, 0, 0, 0, st, rv, ev);
        chk("lb", rv, 32'hFFFFFF80);
        do_req(1, 0, 32'h103, 0, 1, 0, 0, st, rv, ev);
        chk("lbu", rv, 32'h00000080);
        do_req(1, 0, 32'h102, 1, 0, 0, 0, st, rv, ev);
        chk("lh", rv, 32'hFFFF80FF);
        do_req(1, 0, 32'h100, 1, 1, 0, 0, st, rv, ev);
        chk("lhu", rv, 32'h00007F01);
        do_req(0, 1, 32'h101, 0, 0, 32'h000000AA, 0, st, rv, ev);
        do_req(1, 0, 32'h100, 2, 0, 0, 0, st, rv, ev);
        chk("sb_merge", rv, 32'h80FFAA01);
        do_req(0, 1, 32'h300, 2, 0, 32'h12345678, 0, st, rv, ev);
        do_req(1, 0, 32'h300, 2, 0, 0, 0, st, rv, ev);
        chk("no_alloc_stalls", st, 2);
        chk("no_alloc_rdata", rv, 32'h12345678);
        do_req(1, 0, IOB, 2, 0, 0, 0, st, rv, ev);
        chk("io_stalls", st, 0);
        chk("io_rdata", rv, 32'h5);
        do_req(1, 0, 32'h102, 2, 0, 0, 0, st, rv, ev);
        chk("misaligned_err", {31'd0, ev}, 32'd1);
        do_req(1, 0, 32'h200, 2, 0, 0, 1, st, rv, ev);
        chk("flush_fill_stalls", st, 4);

        // Reset during FILL
        cpu_bus.CPU_ADDR = 32'h400; cpu_bus.CPU_SIZE = 2; cpu_bus.CPU_RD = 1'b1;
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, cpu_bus.CPU_STALL}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, cpu_bus.CPU_STALL}, 32'd0);
        chk("midrst_read", {31'd0, mem_bus.MEM_READ2}, 32'd0);
        chk("midrst_miss", miss_cnt, 32'd0);
        chk("midrst_rdata", cpu_bus.CPU_RDATA, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        clear_model_valid();
        exp_hit = 0; exp_miss = 0; exp_rdata = 0;
        @(posedge clk);
        #1;
        do_req(1, 0, 32'h108, 2, 0, 0, 0, st, rv, ev);
        chk("post_rst_miss", st, 2);
        do_req(1, 0, 32'h300, 2, 0, 0, 0, st, rv, ev);
        chk("post_rst_miss2", st, 2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int          r;
            logic [1:0]  sz;
            logic [31:0] a;
            logic        rd, wr;
            r  = int'($urandom_range(0, 99));
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 2047));
            if ($urandom_range(0, 9) < 8) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if (r < 5) begin
                do_flush();
            end else begin
                if (r < 12) a = IOB + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                wr = (r >= 10) && (r < 40);
                rd = !wr || ($urandom_range(0, 1) == 1);
                do_req(rd, wr, a, sz, 1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 9) == 0), st, rv, ev);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
